// File: rtl/sc_gamestatus_keeper_pkg.sv
// Shared definitions for the game-status keeper: FSM state encoding,
// command codes from the main game FSM, default counter limits and
// saturating 4-bit counter helpers.
package sc_gamestatus_keeper_pkg;

    typedef enum logic [1:0] {
        ST_PLAY     = 2'd0,
        ST_GAMEOVER = 2'd1,
        ST_WIN      = 2'd2
    } state_t;

    // NEXTLEVEL command codes
    localparam logic [3:0] NL_IDLE    = 4'd0;
    localparam logic [3:0] NL_ADVANCE = 4'd1;
    localparam logic [3:0] NL_CLEAR   = 4'd2;
    localparam logic [3:0] NL_WIN     = 4'd3;

    // RESETLEVEL command codes
    localparam logic [2:0] RL_NONE    = 3'd0;
    localparam logic [2:0] RL_RESPAWN = 3'd1;
    localparam logic [2:0] RL_LOSE    = 3'd2;

    localparam int unsigned LIVES_INIT_DEF = 3;
    localparam int unsigned LIVES_MAX_DEF  = 9;
    localparam int unsigned LEVEL_MAX_DEF  = 3;
    localparam int unsigned HOUSES_W_DEF   = 8;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? v : v + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec4(input logic [3:0] v);
        return (v == 4'd0) ? v : v - 4'd1;
    endfunction

endpackage

// File: rtl/sc_gamestatus_keeper_risedet.sv
// Single-bit rising-edge detector. The rise output is combinational from
// the current input and the registered previous value.
module sc_gamestatus_risedet (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev;

    // Remember last cycle's input; cleared on reset so a level held high
    // through reset looks like a fresh rise afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/sc_gamestatus_keeper.sv
// Game-status keeper: owns lives, level and filled-houses registers fed
// back to the main game FSM, and issues frog-respawn / game-over / win.
// Optional build macro SC_GAMESTATUS_BONUSLIFE_EN: every level-up also
// awards a life (saturating at LIVES_MAX).
module sc_gamestatus_keeper
    import sc_gamestatus_keeper_pkg::*;
#(
    parameter int unsigned LIVES_INIT = LIVES_INIT_DEF,
    parameter int unsigned LIVES_MAX  = LIVES_MAX_DEF,
    parameter int unsigned LEVEL_MAX  = LEVEL_MAX_DEF,
    parameter int unsigned HOUSES_W   = HOUSES_W_DEF
) (
    input  logic                SC_STATEMACHINEPRINCIPAL_CLOCK_50,
    input  logic                SC_STATEMACHINEPRINCIPAL_RESET_InHigh,
    input  logic [3:0]          NEXTLEVEL_In,
    input  logic [2:0]          RESETLEVEL_In,
    input  logic                LIVEOUT_In,
    input  logic                LEVELOUT_In,
    input  logic [HOUSES_W-1:0] LEVELOR_In,
    input  logic                START_In,
    output logic [3:0]          LIVECOUNT_Out,
    output logic [3:0]          LEVELCOUNT_Out,
    output logic [HOUSES_W-1:0] HOUSES_Out,
    output logic                FROGRESPAWN_Out,
    output logic                GAMEOVER_Out,
    output logic                WIN_Out
);

    localparam logic [3:0] LIVES_INIT_V = 4'(LIVES_INIT);
    localparam logic [3:0] LEVEL_MAX_V  = 4'(LEVEL_MAX);
`ifdef SC_GAMESTATUS_BONUSLIFE_EN
    localparam logic [3:0] LIVES_MAX_V  = 4'(LIVES_MAX);
`endif

    logic clk;
    logic rst;
    assign clk = SC_STATEMACHINEPRINCIPAL_CLOCK_50;
    assign rst = SC_STATEMACHINEPRINCIPAL_RESET_InHigh;

    logic rise_live;
    logic rise_level;
    logic rise_start;

    sc_gamestatus_risedet u_rise_live (
        .clk (clk), .rst (rst), .d (LIVEOUT_In),  .rise (rise_live)
    );
    sc_gamestatus_risedet u_rise_level (
        .clk (clk), .rst (rst), .d (LEVELOUT_In), .rise (rise_level)
    );
    sc_gamestatus_risedet u_rise_start (
        .clk (clk), .rst (rst), .d (START_In),    .rise (rise_start)
    );

    state_t              state, state_next;
    logic [3:0]          lives, lives_next;
    logic [3:0]          level, level_next;
    logic [HOUSES_W-1:0] houses, houses_next;
    logic                respawn, respawn_next;
    logic                gameover, win;
    logic                life_lost;

    // State and all output registers; flags follow the next state so they
    // are asserted in the same cycle the FSM enters GAMEOVER/WIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_PLAY;
            lives    <= LIVES_INIT_V;
            level    <= 4'd0;
            houses   <= '0;
            respawn  <= 1'b0;
            gameover <= 1'b0;
            win      <= 1'b0;
        end else begin
            state    <= state_next;
            lives    <= lives_next;
            level    <= level_next;
            houses   <= houses_next;
            respawn  <= respawn_next;
            gameover <= (state_next == ST_GAMEOVER);
            win      <= (state_next == ST_WIN);
        end
    end

    // Next-state and counter updates. LOSE and WIN commands freeze every
    // counter; otherwise life, level and houses updates apply together.
    always_comb begin
        state_next   = state;
        lives_next   = lives;
        level_next   = level;
        houses_next  = houses;
        respawn_next = 1'b0;
        life_lost    = 1'b0;
        case (state)
            ST_PLAY: begin
                if (RESETLEVEL_In == RL_LOSE) begin
                    state_next = ST_GAMEOVER;
                end else if (NEXTLEVEL_In == NL_WIN) begin
                    state_next = ST_WIN;
                end else begin
                    life_lost = rise_live && (RESETLEVEL_In == RL_NONE);
                    if (rise_live && (RESETLEVEL_In == RL_NONE || RESETLEVEL_In == RL_RESPAWN))
                        respawn_next = 1'b1;
                    if (rise_level)
                        level_next = sat_inc4(level, LEVEL_MAX_V);
`ifdef SC_GAMESTATUS_BONUSLIFE_EN
                    // A bonus life and a lost life in the same cycle cancel.
                    if (rise_level && !life_lost)
                        lives_next = sat_inc4(lives, LIVES_MAX_V);
                    else if (life_lost && !rise_level)
                        lives_next = sat_dec4(lives);
`else
                    if (life_lost)
                        lives_next = sat_dec4(lives);
`endif
                    houses_next = (NEXTLEVEL_In == NL_CLEAR) ? '0 : LEVELOR_In;
                end
            end
            default: begin
                if (rise_start) begin
                    state_next  = ST_PLAY;
                    lives_next  = LIVES_INIT_V;
                    level_next  = 4'd0;
                    houses_next = '0;
                end
            end
        endcase
    end

    assign LIVECOUNT_Out   = lives;
    assign LEVELCOUNT_Out  = level;
    assign HOUSES_Out      = houses;
    assign FROGRESPAWN_Out = respawn;
    assign GAMEOVER_Out    = gameover;
    assign WIN_Out         = win;

endmodule
